// File: rtl/hazard_fwd_if.sv
// Bundle between the pipeline datapath and the hazard/forwarding controller.
// The master side is the pipeline; the slave side is the controller.
interface hazard_fwd_if #(
  parameter int unsigned RW = 5
);
  logic          enable;
  logic          dmem_wait;
  logic          imem_wait;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_branch;
  logic          id_mc;
  logic [RW-1:0] id_mc_wreg;
  logic          ex_regwrite;
  logic [RW-1:0] ex_wreg;
  logic          ex_is_load;
  logic          mem_regwrite;
  logic [RW-1:0] mem_wreg;
  logic          wb_regwrite;
  logic [RW-1:0] wb_wreg;
  logic          pc_write;
  logic          ifid_write;
  logic          bubble;
  logic          pipe_en;
  logic          imem_en;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          mc_busy;
  logic          mc_done;

  modport master (
    output enable, dmem_wait, imem_wait, id_rs, id_rt, id_use_rs, id_use_rt,
           id_branch, id_mc, id_mc_wreg, ex_regwrite, ex_wreg, ex_is_load,
           mem_regwrite, mem_wreg, wb_regwrite, wb_wreg,
    input  pc_write, ifid_write, bubble, pipe_en, imem_en, fwd_a, fwd_b,
           mc_busy, mc_done
  );

  modport slave (
    input  enable, dmem_wait, imem_wait, id_rs, id_rt, id_use_rs, id_use_rt,
           id_branch, id_mc, id_mc_wreg, ex_regwrite, ex_wreg, ex_is_load,
           mem_regwrite, mem_wreg, wb_regwrite, wb_wreg,
    output pc_write, ifid_write, bubble, pipe_en, imem_en, fwd_a, fwd_b,
           mc_busy, mc_done
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage mMIPS pipeline:
// load-use stalls, multi-cycle-op scoreboard and a branch-bubble FSM.
module hazard_fwd_unit #(
  parameter int unsigned RW       = 5,
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned BR_SLOTS = 1,
  parameter int unsigned MC_LAT   = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_fwd_if.slave  bus
);

  localparam int unsigned BR_W = 2;
  localparam int unsigned MC_W = 4;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  typedef enum logic {ST_RUN, ST_BR} state_t;

  state_t          state_q, state_d;
  logic [BR_W-1:0] br_cnt_q, br_cnt_d;
  logic            mc_busy_q, mc_busy_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [RW-1:0]   mc_wreg_q, mc_wreg_d;
  logic            mc_done_q, mc_done_d;

  logic adv, wait_any;
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, mc_a, mc_b;
  logic data_stall, struct_stall, stall;
  logic [1:0] fwd_a_c, fwd_b_c;

  function automatic logic hit(input logic use_r, input logic [RW-1:0] r,
                               input logic [RW-1:0] w, input logic we);
    return use_r && (r != '0) && (r == w) && we;
  endfunction

  // Source-operand matches, stall decision and forwarding selects
  always_comb begin
    adv      = bus.enable & ~bus.dmem_wait & ~bus.imem_wait;
    wait_any = bus.dmem_wait | bus.imem_wait;
    ex_a  = hit(bus.id_use_rs, bus.id_rs, bus.ex_wreg,  bus.ex_regwrite);
    ex_b  = hit(bus.id_use_rt, bus.id_rt, bus.ex_wreg,  bus.ex_regwrite);
    mem_a = hit(bus.id_use_rs, bus.id_rs, bus.mem_wreg, bus.mem_regwrite);
    mem_b = hit(bus.id_use_rt, bus.id_rt, bus.mem_wreg, bus.mem_regwrite);
    wb_a  = hit(bus.id_use_rs, bus.id_rs, bus.wb_wreg,  bus.wb_regwrite);
    wb_b  = hit(bus.id_use_rt, bus.id_rt, bus.wb_wreg,  bus.wb_regwrite);
    mc_a  = hit(bus.id_use_rs, bus.id_rs, mc_wreg_q, mc_busy_q);
    mc_b  = hit(bus.id_use_rt, bus.id_rt, mc_wreg_q, mc_busy_q);
    if (FWD_EN) data_stall = (bus.ex_is_load & (ex_a | ex_b)) | mc_a | mc_b;
    else        data_stall = ex_a | ex_b | mem_a | mem_b | wb_a | wb_b | mc_a | mc_b;
    struct_stall = bus.id_mc & mc_busy_q & ~mc_done_q;
    stall        = data_stall | struct_stall;
    fwd_a_c = FWD_RF;
    fwd_b_c = FWD_RF;
    if (FWD_EN) begin
      if (ex_a)       fwd_a_c = FWD_EXM;
      else if (mem_a) fwd_a_c = FWD_MWB;
      if (ex_b)       fwd_b_c = FWD_EXM;
      else if (mem_b) fwd_b_c = FWD_MWB;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      br_cnt_q  <= '0;
      mc_busy_q <= 1'b0;
      mc_cnt_q  <= '0;
      mc_wreg_q <= '0;
      mc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_cnt_q  <= br_cnt_d;
      mc_busy_q <= mc_busy_d;
      mc_cnt_q  <= mc_cnt_d;
      mc_wreg_q <= mc_wreg_d;
      mc_done_q <= mc_done_d;
    end
  end

  // Next state: everything holds unless the pipeline advances
  always_comb begin
    state_d   = state_q;
    br_cnt_d  = br_cnt_q;
    mc_busy_d = mc_busy_q;
    mc_cnt_d  = mc_cnt_q;
    mc_wreg_d = mc_wreg_q;
    mc_done_d = mc_done_q;
    if (adv) begin
      case (state_q)
        ST_RUN: if (!stall && bus.id_branch) begin
          state_d  = ST_BR;
          br_cnt_d = BR_W'(BR_SLOTS);
        end
        ST_BR: if (br_cnt_q == BR_W'(1)) begin
          state_d  = ST_RUN;
          br_cnt_d = '0;
        end else begin
          br_cnt_d = br_cnt_q - BR_W'(1);
        end
      endcase
      mc_done_d = 1'b0;
      if (state_q == ST_RUN && !stall && bus.id_mc) begin
        mc_busy_d = 1'b1;
        mc_cnt_d  = MC_W'(MC_LAT);
        mc_wreg_d = bus.id_mc_wreg;
      end else if (mc_busy_q) begin
        if (mc_cnt_q == MC_W'(1)) begin
          mc_busy_d = 1'b0;
          mc_cnt_d  = '0;
          mc_done_d = 1'b1;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end
      end
    end
  end

  // Pipeline controls by priority: reset/disable, wait, stall, BR, branch, normal
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ifid_write = 1'b0;
    bus.bubble     = 1'b0;
    bus.pipe_en    = 1'b0;
    bus.imem_en    = 1'b0;
    bus.fwd_a      = FWD_RF;
    bus.fwd_b      = FWD_RF;
    if (!rst && bus.enable) begin
      bus.fwd_a = fwd_a_c;
      bus.fwd_b = fwd_b_c;
      if (wait_any) begin
        bus.bubble  = stall;
        bus.imem_en = ~bus.dmem_wait;
      end else if (stall) begin
        bus.bubble  = 1'b1;
        bus.pipe_en = 1'b1;
      end else if (state_q == ST_BR) begin
        bus.bubble   = 1'b1;
        bus.pc_write = 1'b1;
        bus.imem_en  = 1'b1;
        bus.pipe_en  = 1'b1;
      end else if (bus.id_branch) begin
        bus.ifid_write = 1'b1;
        bus.pipe_en    = 1'b1;
      end else begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.imem_en    = 1'b1;
        bus.pipe_en    = 1'b1;
      end
    end
  end

  assign bus.mc_busy = mc_busy_q;
  assign bus.mc_done = mc_done_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a forwarding instance (BR_SLOTS=2) and a
// legacy stall-only instance (BR_SLOTS=1) driven with identical stimulus.
module tb_hazard_fwd_unit;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_if #(.RW(RW)) fi ();
  hazard_fwd_if #(.RW(RW)) li ();

  hazard_fwd_unit #(.RW(RW), .FWD_EN(1'b1), .BR_SLOTS(2), .MC_LAT(4)) u_fwd (
    .clk(clk), .rst(rst), .bus(fi.slave));
  hazard_fwd_unit #(.RW(RW), .FWD_EN(1'b0), .BR_SLOTS(1), .MC_LAT(4)) u_leg (
    .clk(clk), .rst(rst), .bus(li.slave));

  typedef struct {
    logic en, dw, iw;
    logic [RW-1:0] rs, rt;
    logic urs, urt, br, mc;
    logic [RW-1:0] mcw;
    logic exw; logic [RW-1:0] exr; logic exl;
    logic memw; logic [RW-1:0] memr;
    logic wbw; logic [RW-1:0] wbr;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [8:0] ef;  // {pc, ifid, bubble, pipe, imem, fwd_a, fwd_b}, forwarding unit
    logic [8:0] el;  // same, legacy unit
  } vec_t;

  in_t  cur;
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always_comb begin
    fi.enable = cur.en;         li.enable = cur.en;
    fi.dmem_wait = cur.dw;      li.dmem_wait = cur.dw;
    fi.imem_wait = cur.iw;      li.imem_wait = cur.iw;
    fi.id_rs = cur.rs;          li.id_rs = cur.rs;
    fi.id_rt = cur.rt;          li.id_rt = cur.rt;
    fi.id_use_rs = cur.urs;     li.id_use_rs = cur.urs;
    fi.id_use_rt = cur.urt;     li.id_use_rt = cur.urt;
    fi.id_branch = cur.br;      li.id_branch = cur.br;
    fi.id_mc = cur.mc;          li.id_mc = cur.mc;
    fi.id_mc_wreg = cur.mcw;    li.id_mc_wreg = cur.mcw;
    fi.ex_regwrite = cur.exw;   li.ex_regwrite = cur.exw;
    fi.ex_wreg = cur.exr;       li.ex_wreg = cur.exr;
    fi.ex_is_load = cur.exl;    li.ex_is_load = cur.exl;
    fi.mem_regwrite = cur.memw; li.mem_regwrite = cur.memw;
    fi.mem_wreg = cur.memr;     li.mem_wreg = cur.memr;
    fi.wb_regwrite = cur.wbw;   li.wb_regwrite = cur.wbw;
    fi.wb_wreg = cur.wbr;       li.wb_wreg = cur.wbr;
  end

  logic [8:0] out_f, out_l, mc_f;
  assign out_f = {fi.pc_write, fi.ifid_write, fi.bubble, fi.pipe_en, fi.imem_en, fi.fwd_a, fi.fwd_b};
  assign out_l = {li.pc_write, li.ifid_write, li.bubble, li.pipe_en, li.imem_en, li.fwd_a, li.fwd_b};
  assign mc_f  = {7'b0, fi.mc_busy, fi.mc_done};

  localparam logic [8:0] NORMAL = 9'b11011_00_00;
  localparam logic [8:0] STALL  = 9'b00110_00_00;
  localparam logic [8:0] BR_ID  = 9'b01010_00_00;
  localparam logic [8:0] BR_BUB = 9'b10111_00_00;
  localparam logic [8:0] ZERO   = 9'b0;

  function automatic in_t mk(input logic en, dw, iw, input logic [RW-1:0] rs, rt,
                             input logic urs, urt, exw, input logic [RW-1:0] exr,
                             input logic exl, memw, input logic [RW-1:0] memr,
                             input logic wbw, input logic [RW-1:0] wbr);
    in_t t;
    t.en = en; t.dw = dw; t.iw = iw; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.br = 1'b0; t.mc = 1'b0; t.mcw = '0;
    t.exw = exw; t.exr = exr; t.exl = exl; t.memw = memw; t.memr = memr;
    t.wbw = wbw; t.wbr = wbr;
    return t;
  endfunction

  function automatic in_t idle();
    return mk(1,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0);
  endfunction

  task automatic add(input string nm, input in_t i, input logic [8:0] ef, input logic [8:0] el);
    vec_t v;
    v.name = nm; v.i = i; v.ef = ef; v.el = el;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single-cycle vectors; all keep the FSM in RUN and the scoreboard idle
    add("idle",          mk(1,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0), NORMAL, NORMAL);
    add("ex_fwd_rs",     mk(1,0,0, 3,1,1,0, 1,3,0, 0,0, 0,0), 9'b11011_01_00, STALL);
    add("mem_fwd_rt",    mk(1,0,0, 1,5,0,1, 0,0,0, 1,5, 0,0), 9'b11011_00_10, STALL);
    add("ex_over_mem",   mk(1,0,0, 7,7,1,1, 1,7,0, 1,7, 0,0), 9'b11011_01_01, STALL);
    add("load_use_rt",   mk(1,0,0, 2,5,1,1, 1,5,1, 0,0, 0,0), 9'b00110_00_01, STALL);
    add("load_use_mix",  mk(1,0,0, 5,6,1,1, 1,5,1, 1,6, 0,0), 9'b00110_01_10, STALL);
    add("r0_all",        mk(1,0,0, 0,0,1,1, 1,0,1, 1,0, 1,0), NORMAL, NORMAL);
    add("unused_src",    mk(1,0,0, 4,4,0,0, 1,4,1, 1,4, 1,4), NORMAL, NORMAL);
    add("no_regwrite",   mk(1,0,0, 6,6,1,1, 0,6,1, 0,6, 0,6), NORMAL, NORMAL);
    add("wb_only",       mk(1,0,0, 9,0,1,0, 0,0,0, 0,0, 1,9), NORMAL, STALL);
    add("disabled",      mk(0,0,0, 3,0,1,0, 1,3,0, 0,0, 0,0), ZERO, ZERO);
    add("disabled_load", mk(0,0,0, 2,5,1,1, 1,5,1, 0,0, 0,0), ZERO, ZERO);
    add("dmem_wait",     mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 0,0), ZERO, ZERO);
    add("imem_wait",     mk(1,0,1, 0,0,0,0, 0,0,0, 0,0, 0,0), 9'b00001_00_00, 9'b00001_00_00);
    add("dwait_loaduse", mk(1,1,0, 2,5,1,1, 1,5,1, 0,0, 0,0), 9'b00100_00_01, 9'b00100_00_00);
    add("iwait_fwd",     mk(1,0,1, 3,0,1,0, 1,3,0, 0,0, 0,0), 9'b00001_01_00, 9'b00101_00_00);
    add("both_wait_mem", mk(1,1,1, 1,5,0,1, 0,0,0, 1,5, 0,0), 9'b00000_00_10, 9'b00100_00_00);

    // Reset
    rst = 1'b1;
    cur = idle();
    #2;
    chk("rst_out_fwd", out_f, ZERO);
    chk("rst_out_leg", out_l, ZERO);
    tick();
    chk("rst_mc", mc_f, 9'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_out", out_f, NORMAL);
    tick();

    foreach (tbl[k]) begin
      cur = tbl[k].i;
      #1;
      chk($sformatf("%s/fwd", tbl[k].name), out_f, tbl[k].ef);
      chk($sformatf("%s/leg", tbl[k].name), out_l, tbl[k].el);
      tick();
    end

    // Load-use: one bubble, then MEM/WB forwarding
    cur = mk(1,0,0, 0,5,0,1, 1,5,1, 0,0, 0,0);
    #1; chk("lu_c0", out_f, 9'b00110_00_01);
    tick();
    cur = mk(1,0,0, 0,5,0,1, 0,0,0, 1,5, 0,0);
    #1; chk("lu_c1", out_f, 9'b11011_00_10);
    tick();

    // Branch with two bubble slots (legacy instance has one)
    cur = idle(); cur.br = 1'b1;
    #1; chk("br_c0_fwd", out_f, BR_ID); chk("br_c0_leg", out_l, BR_ID);
    tick();
    cur = idle();
    #1; chk("br_c1_fwd", out_f, BR_BUB); chk("br_c1_leg", out_l, BR_BUB);
    tick();
    #1; chk("br_c2_fwd", out_f, BR_BUB); chk("br_c2_leg", out_l, NORMAL);
    tick();
    #1; chk("br_c3_fwd", out_f, NORMAL);
    tick();

    // Branch with imem_wait in the first slot stretches BR by one cycle
    cur = idle(); cur.br = 1'b1;
    #1; chk("brw_c0", out_f, BR_ID);
    tick();
    cur = idle(); cur.iw = 1'b1;
    #1; chk("brw_c1_wait", out_f, 9'b00001_00_00);
    tick();
    cur = idle();
    #1; chk("brw_c2", out_f, BR_BUB);
    tick();
    #1; chk("brw_c3", out_f, BR_BUB);
    tick();
    #1; chk("brw_c4", out_f, NORMAL);
    tick();

    // mult to r8, dependent instruction stalls MC_LAT cycles
    cur = idle(); cur.mc = 1'b1; cur.mcw = 5'd8;
    #1; chk("mc_issue", out_f, NORMAL);
    tick();
    cur = idle(); cur.rs = 5'd8; cur.urs = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mc_dep_stall_c%0d", c), out_f, STALL);
      chk($sformatf("mc_busy_c%0d", c), mc_f, 9'b10);
      tick();
    end
    cur.dw = 1'b1;
    #1; chk("mc_done_c5", mc_f, 9'b01); chk("mc_c5_wait", out_f, ZERO);
    tick();
    cur.dw = 1'b0;
    #1; chk("mc_done_held", mc_f, 9'b01); chk("mc_dep_go", out_f, NORMAL);
    tick();
    #1; chk("mc_done_clr", mc_f, 9'b00);

    // Back-to-back mults: second stalls structurally, issues on mc_done
    cur = idle(); cur.mc = 1'b1; cur.mcw = 5'd9;
    #1; chk("mc2_issue", out_f, NORMAL);
    tick();
    cur.mcw = 5'd10;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mc2_struct_c%0d", c), out_f, STALL);
      tick();
    end
    #1; chk("mc2_done", mc_f, 9'b01); chk("mc2_accept", out_f, NORMAL);
    tick();
    cur = idle(); cur.rs = 5'd10; cur.urs = 1'b1;
    #1; chk("mc2_reload", mc_f, 9'b10); chk("mc2_wreg10", out_f, STALL);
    tick();
    cur = idle();
    for (int c = 0; c < 3; c++) tick();
    #1; chk("mc2_done2", mc_f, 9'b01);
    tick();
    chk("mc2_idle", mc_f, 9'b00);

    // Reset while a mult is in flight and the FSM is in BR
    cur = idle(); cur.mc = 1'b1; cur.mcw = 5'd12;
    tick();
    cur = idle(); cur.br = 1'b1;
    tick();
    cur = idle();
    rst = 1'b1;
    #1; chk("rst_mid_fwd", out_f, ZERO); chk("rst_mid_leg", out_l, ZERO);
    tick();
    rst = 1'b0;
    #1; chk("rst_mid_mc", mc_f, 9'b00); chk("rst_mid_run", out_f, NORMAL);
    tick();
    chk("rst_mid_nodone", mc_f, 9'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
